// File: rtl/eq_pkg.sv
// Shared types for the ILA-vs-HLS output-stream miter: run states and verdict codes.
package eq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FK_NONE    = 2'd0,
        FK_DATA    = 2'd1,
        FK_COUNT   = 2'd2,
        FK_TIMEOUT = 2'd3
    } fail_kind_t;

    function automatic logic is_active(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/eq_stream_miter_if.sv
// Harness-facing bundle of the miter: run control, both output streams and the verdict.
interface eq_stream_miter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              ila_complete;
    logic              hls_complete;
    logic              sink_rdy;
    logic              ila_vld;
    logic [DATA_W-1:0] ila_data;
    logic              hls_vld;
    logic [DATA_W-1:0] hls_data;
    logic              ila_ce;
    logic              hls_ce;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_kind;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] act_data;

    // Harness side: drives run control and the two DUT output streams.
    modport master (
        output start, ila_complete, hls_complete, sink_rdy,
        output ila_vld, ila_data, hls_vld, hls_data,
        input  ila_ce, hls_ce, busy, pass, fail, fail_kind,
        input  beat_cnt, exp_data, act_data
    );

    // Miter side.
    modport slave (
        input  start, ila_complete, hls_complete, sink_rdy,
        input  ila_vld, ila_data, hls_vld, hls_data,
        output ila_ce, hls_ce, busy, pass, fail, fail_kind,
        output beat_cnt, exp_data, act_data
    );
endinterface

// File: rtl/eq_sync_fifo.sv
// Small in-order skew buffer: registered count and pointers, head visible combinationally.
module eq_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/eq_stream_miter.sv
// Output-stream miter: gates each side with a clock enable, buffers its beats and
// compares them pairwise, then reports a sticky equivalent/non-equivalent verdict.
module eq_stream_miter
    import eq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int ILA_GRACE = 0,
    parameter int HLS_GRACE = 5,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    eq_stream_miter_if.slave bus
);
    localparam logic [CNT_W-1:0] ILA_LIM = CNT_W'(ILA_GRACE);
    localparam logic [CNT_W-1:0] HLS_LIM = CNT_W'(HLS_GRACE);
    localparam logic [CNT_W-1:0] TMO_MAX = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  ila_wait_q, ila_wait_d;
    logic [CNT_W-1:0]  hls_wait_q, hls_wait_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    fail_kind_t        kind_q, kind_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] act_q, act_d;

    logic              run, active, restart;
    logic              ila_done, hls_done;
    logic              ila_push, hls_push, pop_both;
    logic              ila_full, ila_empty, hls_full, hls_empty;
    logic              both_ne, heads_eq;
    logic [DATA_W-1:0] ila_head, hls_head;

    // Grace counter: counts consecutive complete cycles, saturating one past the limit.
    function automatic logic [CNT_W-1:0] grace_next(input logic [CNT_W-1:0] w,
                                                    input logic              cmpl,
                                                    input logic [CNT_W-1:0] lim);
        if (!cmpl)    return '0;
        if (w > lim)  return w;
        return w + CNT_W'(1);
    endfunction

    assign run      = (state_q == RUN);
    assign active   = is_active(state_q);
    assign restart  = bus.start & ~active;
    assign ila_done = (ila_wait_q > ILA_LIM);
    assign hls_done = (hls_wait_q > HLS_LIM);

    // Enables look only at registered occupancy, so a same-cycle pop never frees a full side.
    assign bus.ila_ce = run & ~ila_done & ~ila_full;
    assign bus.hls_ce = run & ~hls_done & ~hls_full;

    assign ila_push = bus.ila_vld & bus.sink_rdy & bus.ila_ce;
    assign hls_push = bus.hls_vld & bus.sink_rdy & bus.hls_ce;
    assign both_ne  = ~ila_empty & ~hls_empty;
    assign heads_eq = (ila_head == hls_head);
    assign pop_both = active & both_ne & heads_eq;

    eq_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ila_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (restart),
        .push_i  (ila_push),
        .pop_i   (pop_both),
        .din_i   (bus.ila_data),
        .head_o  (ila_head),
        .full_o  (ila_full),
        .empty_o (ila_empty)
    );

    eq_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_hls_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (restart),
        .push_i  (hls_push),
        .pop_i   (pop_both),
        .din_i   (bus.hls_data),
        .head_o  (hls_head),
        .full_o  (hls_full),
        .empty_o (hls_empty)
    );

    always_comb begin
        state_d    = state_q;
        ila_wait_d = ila_wait_q;
        hls_wait_d = hls_wait_q;
        tmo_d      = tmo_q;
        beat_d     = beat_q;
        kind_d     = kind_q;
        exp_d      = exp_q;
        act_d      = act_q;
        if (restart) begin
            state_d    = RUN;
            ila_wait_d = '0;
            hls_wait_d = '0;
            tmo_d      = '0;
            beat_d     = '0;
            kind_d     = FK_NONE;
            exp_d      = '0;
            act_d      = '0;
        end else if (active) begin
            tmo_d = tmo_q + CNT_W'(1);
            if (run) begin
                ila_wait_d = grace_next(ila_wait_q, bus.ila_complete, ILA_LIM);
                hls_wait_d = grace_next(hls_wait_q, bus.hls_complete, HLS_LIM);
            end
            if (pop_both) beat_d = beat_q + CNT_W'(1);
            // Verdict priority: data mismatch, timeout, drain outcome, then RUN->DRAIN.
            if (both_ne && !heads_eq) begin
                state_d = FAIL;
                kind_d  = FK_DATA;
                exp_d   = ila_head;
                act_d   = hls_head;
            end else if (tmo_q == TMO_MAX) begin
                state_d = FAIL;
                kind_d  = FK_TIMEOUT;
            end else if (state_q == DRAIN) begin
                if (ila_empty && hls_empty) begin
                    state_d = PASS;
                end else if (ila_empty || hls_empty) begin
                    state_d = FAIL;
                    kind_d  = FK_COUNT;
                    exp_d   = ila_empty ? '0 : ila_head;
                    act_d   = hls_empty ? '0 : hls_head;
                end
            end else if ((ila_wait_d > ILA_LIM) && (hls_wait_d > HLS_LIM)) begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ila_wait_q <= '0;
            hls_wait_q <= '0;
            tmo_q      <= '0;
            beat_q     <= '0;
            kind_q     <= FK_NONE;
            exp_q      <= '0;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            ila_wait_q <= ila_wait_d;
            hls_wait_q <= hls_wait_d;
            tmo_q      <= tmo_d;
            beat_q     <= beat_d;
            kind_q     <= kind_d;
            exp_q      <= exp_d;
            act_q      <= act_d;
        end
    end

    assign bus.busy      = active;
    assign bus.pass      = (state_q == PASS);
    assign bus.fail      = (state_q == FAIL);
    assign bus.fail_kind = kind_q;
    assign bus.beat_cnt  = beat_q;
    assign bus.exp_data  = exp_q;
    assign bus.act_data  = act_q;
endmodule

// File: tb/tb_eq_stream_miter.sv
// Table-driven bench for eq_stream_miter with a verdict scoreboard and a few hand-built sequences.
module tb_eq_stream_miter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eq_stream_miter_if #(.DATA_W(8), .CNT_W(16)) bus ();

    eq_stream_miter #(
        .DATA_W(8), .DEPTH(4), .ILA_GRACE(0), .HLS_GRACE(5), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Beat lists: first beat in the least significant byte.
    typedef struct packed {
        int              n_i;
        int              n_h;
        logic [4:0][7:0] ib;
        logic [4:0][7:0] hb;
        int              dly_i;
        int              dly_h;
        int              cmpl;
        logic            e_pass;
        logic [1:0]      e_kind;
        int              e_beats;
        logic [7:0]      e_exp;
        logic [7:0]      e_act;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ila_ce"},   32'(bus.ila_ce),    32'd0);
        chk({tag, "_hls_ce"},   32'(bus.hls_ce),    32'd0);
        chk({tag, "_busy"},     32'(bus.busy),      32'd0);
        chk({tag, "_pass"},     32'(bus.pass),      32'd0);
        chk({tag, "_fail"},     32'(bus.fail),      32'd0);
        chk({tag, "_kind"},     32'(bus.fail_kind), 32'd0);
        chk({tag, "_beat_cnt"}, 32'(bus.beat_cnt),  32'd0);
        chk({tag, "_exp_data"}, 32'(bus.exp_data),  32'd0);
        chk({tag, "_act_data"}, 32'(bus.act_data),  32'd0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int   ii = 0, hi = 0, occ_i = 0, occ_h = 0;
        bit   fi, fh, popm, got = 1'b0;
        vec_t e;
        sb_q.push_back(v);
        pulse_start();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.sink_rdy     = 1'b1;
            bus.ila_vld      = (cyc >= v.dly_i) && (ii < v.n_i);
            bus.hls_vld      = (cyc >= v.dly_h) && (hi < v.n_h);
            bus.ila_data     = (ii < v.n_i) ? v.ib[ii] : 8'h00;
            bus.hls_data     = (hi < v.n_h) ? v.hb[hi] : 8'h00;
            bus.ila_complete = (ii == v.n_i) && (cyc >= v.cmpl);
            bus.hls_complete = (hi == v.n_h) && (cyc >= v.cmpl);
            @(negedge clk);
            if (bus.pass || bus.fail) begin
                got = 1'b1;
                break;
            end
            // A full skew buffer must hold its side's enable low.
            if (occ_i == 4) chk($sformatf("v%0d_ila_ce_full", id), 32'(bus.ila_ce), 32'd0);
            if (occ_h == 4) chk($sformatf("v%0d_hls_ce_full", id), 32'(bus.hls_ce), 32'd0);
            fi = bus.ila_vld & bus.ila_ce & bus.sink_rdy;
            fh = bus.hls_vld & bus.hls_ce & bus.sink_rdy;
            @(posedge clk); #1;
            popm  = (occ_i > 0) && (occ_h > 0);
            occ_i = occ_i + int'(fi) - int'(popm);
            occ_h = occ_h + int'(fh) - int'(popm);
            if (fi) ii++;
            if (fh) hi++;
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_verdict_timeout: got no verdict expected pass=%0b", id, e.e_pass);
        end else begin
            $display("vec %0d: pass=%0b fail=%0b kind=%0d beats=%0d exp=%02h act=%02h",
                     id, bus.pass, bus.fail, bus.fail_kind, bus.beat_cnt, bus.exp_data, bus.act_data);
            chk($sformatf("v%0d_pass", id),     32'(bus.pass),      32'(e.e_pass));
            chk($sformatf("v%0d_fail", id),     32'(bus.fail),      32'(!e.e_pass));
            chk($sformatf("v%0d_kind", id),     32'(bus.fail_kind), 32'(e.e_kind));
            chk($sformatf("v%0d_beat_cnt", id), 32'(bus.beat_cnt),  32'(e.e_beats));
            chk($sformatf("v%0d_exp_data", id), 32'(bus.exp_data),  32'(e.e_exp));
            chk($sformatf("v%0d_act_data", id), 32'(bus.act_data),  32'(e.e_act));
            chk($sformatf("v%0d_ce_off", id),   32'({bus.ila_ce, bus.hls_ce}), 32'd0);
            chk($sformatf("v%0d_busy", id),     32'(bus.busy),      32'd0);
        end
        @(posedge clk); #1;
        bus.ila_vld      = 1'b0;
        bus.hls_vld      = 1'b0;
        bus.ila_complete = 1'b0;
        bus.hls_complete = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  seen;
        // n_i n_h ila beats hls beats dly_i dly_h cmpl | pass kind beats exp act
        vecs[0] = '{3, 3, 40'h0000332211, 40'h0000332211, 0, 0, 10, 1'b1, 2'd0, 3, 8'h00, 8'h00};
        vecs[1] = '{5, 5, 40'h5544332211, 40'h5544332211, 0, 5, 12, 1'b1, 2'd0, 5, 8'h00, 8'h00};
        vecs[2] = '{2, 2, 40'h0000002211, 40'h0000002311, 0, 0, 10, 1'b0, 2'd1, 1, 8'h22, 8'h23};
        vecs[3] = '{3, 2, 40'h0000332211, 40'h0000002211, 0, 0,  6, 1'b0, 2'd2, 2, 8'h33, 8'h00};
        vecs[4] = '{2, 2, 40'h0000005AA5, 40'h0000005AA5, 3, 0,  8, 1'b1, 2'd0, 2, 8'h00, 8'h00};
        vecs[5] = '{1, 2, 40'h0000000001, 40'h0000000201, 0, 0,  6, 1'b0, 2'd2, 1, 8'h00, 8'h02};
        vecs[6] = '{0, 0, 40'h0000000000, 40'h0000000000, 0, 0,  2, 1'b1, 2'd0, 0, 8'h00, 8'h00};
        vecs[7] = '{1, 1, 40'h00000000FF, 40'h0000000000, 0, 0,  5, 1'b0, 2'd1, 0, 8'hFF, 8'h00};

        bus.start = 1'b0; bus.sink_rdy = 1'b0;
        bus.ila_complete = 1'b0; bus.hls_complete = 1'b0;
        bus.ila_vld = 1'b0; bus.hls_vld = 1'b0;
        bus.ila_data = 8'h00; bus.hls_data = 8'h00;

        #12;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Grace window: complete held high keeps hls_ce on for HLS_GRACE+1 cycles.
        pulse_start();
        bus.hls_complete = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.hls_ce) cnt++;
            @(posedge clk); #1;
        end
        $display("grace: hls_ce high for %0d cycles", cnt);
        chk("grace_ce_cycles", 32'(cnt), 32'd6);
        bus.hls_complete = 1'b0;
        @(negedge clk);
        chk("grace_ce_still_off", 32'(bus.hls_ce), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("grace_ce_resumed", 32'(bus.hls_ce), 32'd1);
        @(posedge clk); #1;
        bus.ila_complete = 1'b1;
        bus.hls_complete = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            seen = bus.pass | bus.fail;
        end
        chk("grace_run_pass", 32'(bus.pass), 32'd1);
        chk("grace_run_beats", 32'(bus.beat_cnt), 32'd0);
        @(posedge clk); #1;
        bus.ila_complete = 1'b0;
        bus.hls_complete = 1'b0;

        // Asynchronous reset in the middle of a run, away from any clock edge.
        pulse_start();
        bus.sink_rdy = 1'b1;
        bus.ila_vld = 1'b1; bus.ila_data = 8'h11;
        bus.hls_vld = 1'b1; bus.hls_data = 8'h11;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.ila_vld = 1'b0;
        bus.hls_vld = 1'b0;
        @(negedge clk);
        chk("mid_run_busy", 32'(bus.busy), 32'd1);
        chk("mid_run_beats", 32'(bus.beat_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        $display("async reset applied mid-run");
        check_zero("async_rst");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(bus.busy), 32'd0);
        run_vec(8, vecs[0]);

        // Timeout: a run whose sides never complete must end with kind 3.
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 70000 && !seen; c++) begin
            @(negedge clk);
            seen = bus.fail | bus.pass;
        end
        $display("timeout run: fail=%0b kind=%0d", bus.fail, bus.fail_kind);
        chk("timeout_fail", 32'(bus.fail), 32'd1);
        chk("timeout_kind", 32'(bus.fail_kind), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
